jogo_memoria_param: RTL and testbench

- Parametrised successor of the memory-game core: a sequence-repeat game, Genius/Simon style.
- Generalised to N_CH buttons/LEDs, N_RODADAS rounds and a configurable play timeout.
- Adds two behaviours the previous generation lacked: an LED playback phase before each round, and a fast mode.
- Merges control unit and datapath in one block; hex displays stay outside it. The sequence memory is external (combinational read).

---
 rtl/jogo_pkg.sv | 34 +++
 rtl/jogo_memoria_param_contador_m.sv | 38 +++
 rtl/jogo_memoria_param.sv | 189 ++++++++++++++++++
 tb/tb_jogo_memoria_param.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the parametrised memory game.
// - estado_t: FSM states; each enum value is the code shown on db_estado.
// - largura_cont(): width of a counter that runs 0..n-1. It is also used for
//   the sequence address and the play timer, and is never less than 1 bit.
// - largura_end() / largura_timer(): named wrappers for those two uses.
package jogo_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    MOSTRA      = 4'h2,
    INTERVALO   = 4'h3,
    ESPERA      = 4'h4,
    REGISTRA    = 4'h5,
    COMPARA     = 4'h6,
    PROX_JOGADA = 4'h7,
    PROX_RODADA = 4'h8,
    GANHOU      = 4'hA,
    PERDEU      = 4'hE
  } estado_t;

  function automatic int largura_cont(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int largura_end(input int n_rodadas);
    return largura_cont(n_rodadas);
  endfunction

  function automatic int largura_timer(input int ciclos);
    return largura_cont(ciclos);
  endfunction

endpackage

// File: rtl/jogo_memoria_param_contador_m.sv
// contador_m: a mod-M up counter.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   i_zera       : synchronous clear; it has priority over i_conta
//   i_conta      : count enable; the counter wraps from M-1 back to 0
//   o_valor      : current count
//   o_fim        : high while the count equals M-1
module contador_m
  import jogo_pkg::*;
#(
  parameter int M = 4,
  parameter int W = largura_cont(M)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_zera,
  input  logic         i_conta,
  output logic [W-1:0] o_valor,
  output logic         o_fim
);

  logic [W-1:0] r_valor;

  // NOTE: clocked state is written with non-blocking (<=) assignments so that
  // every flop samples values from before the edge, whatever the order in
  // which the blocks are evaluated.
  always_ff @(posedge clock) begin
    if (reset || i_zera) begin
      r_valor <= '0;
    end else if (i_conta) begin
      r_valor <= (r_valor == W'(M - 1)) ? '0 : r_valor + 1'b1;
    end
  end

  assign o_valor = r_valor;
  assign o_fim   = (r_valor == W'(M - 1));

endmodule

// File: rtl/jogo_memoria_param.sv
// jogo_memoria_param: control unit and datapath of a Simon-style game that
// repeats a sequence. It supports N_CH buttons, N_RODADAS rounds, an LED
// playback before each round and a fast mode that halves the times.
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   iniciar               : start or restart (read in INICIAL/GANHOU/PERDEU)
//   modo                  : 0 normal, 1 fast; latched in PREPARA
//   chaves   [N_CH]       : player buttons (one-hot expected)
//   dado_mem [N_CH]       : external sequence memory data at endereco
//   endereco              : sequence memory address
//   leds     [N_CH]       : playback LEDs
//   rodada                : current round, 0-based
//   pronto/ganhou/perdeu  : game-over flags, held until restart
//   db_timeout            : the loss came from the play timer
//   db_estado[4]          : current state code
module jogo_memoria_param
  import jogo_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int N_RODADAS      = 16,
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int MOSTRA_CICLOS  = 1000
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                iniciar,
  input  logic                                modo,
  input  logic [N_CH-1:0]                     chaves,
  input  logic [N_CH-1:0]                     dado_mem,
  output logic [largura_end(N_RODADAS)-1:0]   endereco,
  output logic [N_CH-1:0]                     leds,
  output logic [largura_end(N_RODADAS)-1:0]   rodada,
  output logic                                pronto,
  output logic                                ganhou,
  output logic                                perdeu,
  output logic                                db_timeout,
  output logic [3:0]                          db_estado
);

  localparam int AW             = largura_end(N_RODADAS);
  localparam int MW             = largura_cont(MOSTRA_CICLOS);
  localparam int TW             = largura_timer(TIMEOUT_CICLOS);
  localparam int MOSTRA_RAPIDO  = MOSTRA_CICLOS / 2;
  localparam int TIMEOUT_RAPIDO = TIMEOUT_CICLOS / 2;

  estado_t         r_estado, w_prox;
  logic            r_modo, r_chaves_ant;
  logic [N_CH-1:0] r_jogada;
  logic            r_pronto, r_ganhou, r_perdeu, r_timeout;

  logic            w_mostra_zera, w_mostra_conta, w_mostra_fim_n, w_mostra_fim;
  logic            w_timer_zera, w_timer_conta, w_timer_fim_n, w_timer_fim;
  logic            w_end_zera, w_end_conta, w_end_fim;
  logic            w_rod_zera, w_rod_conta, w_rod_fim;
  logic [MW-1:0]   w_mostra_q;
  logic [TW-1:0]   w_timer_q;
  logic [AW-1:0]   w_end_q, w_rod_q;

  contador_m #(.M(MOSTRA_CICLOS), .W(MW)) u_mostra (
    .clock(clock), .reset(reset), .i_zera(w_mostra_zera), .i_conta(w_mostra_conta),
    .o_valor(w_mostra_q), .o_fim(w_mostra_fim_n));

  contador_m #(.M(TIMEOUT_CICLOS), .W(TW)) u_timer (
    .clock(clock), .reset(reset), .i_zera(w_timer_zera), .i_conta(w_timer_conta),
    .o_valor(w_timer_q), .o_fim(w_timer_fim_n));

  contador_m #(.M(N_RODADAS), .W(AW)) u_endereco (
    .clock(clock), .reset(reset), .i_zera(w_end_zera), .i_conta(w_end_conta),
    .o_valor(w_end_q), .o_fim(w_end_fim));

  contador_m #(.M(N_RODADAS), .W(AW)) u_rodada (
    .clock(clock), .reset(reset), .i_zera(w_rod_zera), .i_conta(w_rod_conta),
    .o_valor(w_rod_q), .o_fim(w_rod_fim));

  // In fast mode the counters still wrap at the full modulus. The end of a
  // phase is then taken from the halved terminal value.
  assign w_mostra_fim = r_modo ? (w_mostra_q == MW'(MOSTRA_RAPIDO - 1)) : w_mostra_fim_n;
  assign w_timer_fim  = r_modo ? (w_timer_q == TW'(TIMEOUT_RAPIDO - 1)) : w_timer_fim_n;

  logic w_chaves_or, w_jogada, w_igual, w_acerto, w_ultima;
  assign w_chaves_or = |chaves;
  // A play is a 0->1 transition of the OR of the buttons. A button still held
  // when ESPERA is entered does not count as a play until it is released.
  assign w_jogada    = w_chaves_or && !r_chaves_ant;
  assign w_igual     = (w_end_q == w_rod_q);
  assign w_acerto    = (r_jogada == dado_mem);
  // When endereco == rodada, both counters sit at N_RODADAS-1 only in the last round.
  assign w_ultima    = w_end_fim && w_rod_fim;

  always_ff @(posedge clock) begin
    if (reset) r_estado <= INICIAL;
    else       r_estado <= w_prox;
  end

  // NOTE: every signal driven here gets a default before the case statement.
  // A path that leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    w_prox         = r_estado;
    leds           = '0;
    w_mostra_zera  = 1'b1;
    w_mostra_conta = 1'b0;
    w_timer_zera   = 1'b1;
    w_timer_conta  = 1'b0;
    w_end_zera     = 1'b0;
    w_end_conta    = 1'b0;
    w_rod_zera     = 1'b0;
    w_rod_conta    = 1'b0;
    case (r_estado)
      INICIAL: if (iniciar) w_prox = PREPARA;
      PREPARA: begin
        w_end_zera = 1'b1;
        w_rod_zera = 1'b1;
        w_prox     = MOSTRA;
      end
      MOSTRA: begin
        leds = dado_mem;
        if (w_mostra_fim) w_prox = INTERVALO;
        else begin w_mostra_zera = 1'b0; w_mostra_conta = 1'b1; end
      end
      INTERVALO: begin
        if (w_mostra_fim) begin
          if (w_igual) begin w_end_zera = 1'b1; w_prox = ESPERA; end
          else begin w_end_conta = 1'b1; w_prox = MOSTRA; end
        end else begin
          w_mostra_zera  = 1'b0;
          w_mostra_conta = 1'b1;
        end
      end
      ESPERA: begin
        w_timer_zera  = 1'b0;
        w_timer_conta = 1'b1;
        if (w_jogada)         w_prox = REGISTRA;
        else if (w_timer_fim) w_prox = PERDEU;
      end
      REGISTRA: w_prox = COMPARA;
      COMPARA: begin
        if (!w_acerto)     w_prox = PERDEU;
        else if (!w_igual) w_prox = PROX_JOGADA;
        else if (w_ultima) w_prox = GANHOU;
        else               w_prox = PROX_RODADA;
      end
      PROX_JOGADA: begin
        w_end_conta = 1'b1;
        w_prox      = ESPERA;
      end
      PROX_RODADA: begin
        w_rod_conta = 1'b1;
        w_end_zera  = 1'b1;
        w_prox      = MOSTRA;
      end
      GANHOU, PERDEU: if (iniciar) w_prox = PREPARA;
      default: w_prox = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_modo       <= 1'b0;
      r_chaves_ant <= 1'b0;
      r_jogada     <= '0;
      r_pronto     <= 1'b0;
      r_ganhou     <= 1'b0;
      r_perdeu     <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_chaves_ant <= w_chaves_or;
      if (r_estado == PREPARA) begin
        r_modo    <= modo;
        r_pronto  <= 1'b0;
        r_ganhou  <= 1'b0;
        r_perdeu  <= 1'b0;
        r_timeout <= 1'b0;
      end
      if (r_estado == REGISTRA) r_jogada <= chaves;
      if (w_prox == GANHOU) begin r_pronto <= 1'b1; r_ganhou <= 1'b1; end
      if (w_prox == PERDEU) begin r_pronto <= 1'b1; r_perdeu <= 1'b1; end
      if (r_estado == ESPERA && w_prox == PERDEU) r_timeout <= 1'b1;
    end
  end

  assign endereco   = w_end_q;
  assign rodada     = w_rod_q;
  assign pronto     = r_pronto;
  assign ganhou     = r_ganhou;
  assign perdeu     = r_perdeu;
  assign db_timeout = r_timeout;
  assign db_estado  = r_estado;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Directed testbench for jogo_memoria_param (N_CH=4, N_RODADAS=4,
// TIMEOUT_CICLOS=20, MOSTRA_CICLOS=4). Sequence memory: 0001, 0100, 0010, 1000.
module tb_jogo_memoria_param;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       modo = 1'b0;
  logic [3:0] chaves = '0;
  logic [3:0] dado_mem;
  logic [1:0] endereco, rodada;
  logic [3:0] leds, db_estado;
  logic       pronto, ganhou, perdeu, db_timeout;

  int n_checks = 0;
  int n_errors = 0;

  jogo_memoria_param #(
    .N_CH(4), .N_RODADAS(4), .TIMEOUT_CICLOS(20), .MOSTRA_CICLOS(4)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .modo(modo),
    .chaves(chaves), .dado_mem(dado_mem), .endereco(endereco), .leds(leds),
    .rodada(rodada), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu),
    .db_timeout(db_timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] mem_val(input int a);
    case (a)
      0: return 4'b0001;
      1: return 4'b0100;
      2: return 4'b0010;
      default: return 4'b1000;
    endcase
  endfunction

  always_comb dado_mem = mem_val(int'(endereco));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset pulse, then iniciar; returns with the DUT in PREPARA.
  task automatic start_game();
    reset = 1'b1; iniciar = 1'b0; chaves = '0;
    tick();
    reset = 1'b0; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    n_checks++;
    if (db_estado !== 4'h1) begin
      n_errors++; $display("FAIL start_prepara: estado=%h expected 1", db_estado);
    end
  endtask

  // Checks the playback of round r cycle by cycle (tm cycles on, tm cycles off)
  // and ends on the first cycle of ESPERA.
  task automatic playback(input int r, input int tm);
    for (int e = 0; e <= r; e++) begin
      for (int c = 0; c < tm; c++) begin
        tick();
        n_checks++;
        if (db_estado !== 4'h2 || leds !== mem_val(e) || endereco !== 2'(e)) begin
          n_errors++;
          $display("FAIL playback_on r=%0d e=%0d c=%0d: estado=%h leds=%b end=%0d expected 2 %b %0d",
                   r, e, c, db_estado, leds, endereco, mem_val(e), e);
        end
      end
      for (int c = 0; c < tm; c++) begin
        tick();
        n_checks++;
        if (db_estado !== 4'h3 || leds !== 4'b0000) begin
          n_errors++;
          $display("FAIL playback_off r=%0d e=%0d c=%0d: estado=%h leds=%b expected 3 0000",
                   r, e, c, db_estado, leds);
        end
      end
    end
    tick();
    n_checks++;
    if (db_estado !== 4'h4 || endereco !== 2'd0 || rodada !== 2'(r)) begin
      n_errors++;
      $display("FAIL playback_to_espera r=%0d: estado=%h end=%0d rodada=%0d expected 4 0 %0d",
               r, db_estado, endereco, rodada, r);
    end
  endtask

  // One play from ESPERA: the press, then REGISTRA, then COMPARA, then the decision state.
  task automatic jogar(input logic [3:0] val, input logic [3:0] exp_estado);
    chaves = val;
    tick();
    n_checks++;
    if (db_estado !== 4'h5) begin
      n_errors++; $display("FAIL jogar_registra val=%b: estado=%h expected 5", val, db_estado);
    end
    tick();
    n_checks++;
    if (db_estado !== 4'h6) begin
      n_errors++; $display("FAIL jogar_compara val=%b: estado=%h expected 6", val, db_estado);
    end
    chaves = '0;
    tick();
    n_checks++;
    if (db_estado !== exp_estado) begin
      n_errors++;
      $display("FAIL jogar_decisao val=%b: estado=%h expected %h", val, db_estado, exp_estado);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (db_estado !== 4'h0 || leds !== 4'b0 || rodada !== 2'd0 || endereco !== 2'd0 ||
        {pronto, ganhou, perdeu, db_timeout} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_state: estado=%h leds=%b rod=%0d end=%0d flags=%b expected all 0",
               db_estado, leds, rodada, endereco, {pronto, ganhou, perdeu, db_timeout});
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (db_estado !== 4'h0) begin
      n_errors++; $display("FAIL idle_without_iniciar: estado=%h expected 0", db_estado);
    end
  endtask

  task automatic test_win();
    logic [3:0] exp;
    start_game();
    for (int r = 0; r < 4; r++) begin
      playback(r, 4);
      for (int e = 0; e <= r; e++) begin
        exp = (e < r) ? 4'h7 : ((r == 3) ? 4'hA : 4'h8);
        jogar(mem_val(e), exp);
        if (e < r) begin
          tick();
          n_checks++;
          if (db_estado !== 4'h4 || endereco !== 2'(e + 1)) begin
            n_errors++;
            $display("FAIL win_prox_jogada r=%0d e=%0d: estado=%h end=%0d expected 4 %0d",
                     r, e, db_estado, endereco, e + 1);
          end
        end
      end
    end
    tick();
    n_checks++;
    if (db_estado !== 4'hA || {pronto, ganhou, perdeu, db_timeout} !== 4'b1100 || leds !== 4'b0) begin
      n_errors++;
      $display("FAIL win_final: estado=%h pgpt=%b leds=%b expected A 1100 0000",
               db_estado, {pronto, ganhou, perdeu, db_timeout}, leds);
    end
  endtask

  task automatic test_wrong_play();
    start_game();
    playback(0, 4);
    jogar(4'b0001, 4'h8);
    playback(1, 4);
    jogar(4'b0001, 4'h7);
    tick();
    jogar(4'b0010, 4'hE);
    n_checks++;
    if ({pronto, ganhou, perdeu, db_timeout} !== 4'b1010 || rodada !== 2'd1 || endereco !== 2'd1) begin
      n_errors++;
      $display("FAIL wrong_play: pgpt=%b rod=%0d end=%0d expected 1010 1 1",
               {pronto, ganhou, perdeu, db_timeout}, rodada, endereco);
    end
  endtask

  task automatic test_restart();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    n_checks++;
    if (db_estado !== 4'h1) begin
      n_errors++; $display("FAIL restart_prepara: estado=%h expected 1", db_estado);
    end
    tick();
    n_checks++;
    if (db_estado !== 4'h2 || rodada !== 2'd0 || endereco !== 2'd0 || leds !== 4'b0001 ||
        {pronto, ganhou, perdeu, db_timeout} !== 4'b0000) begin
      n_errors++;
      $display("FAIL restart_mostra: estado=%h rod=%0d end=%0d leds=%b flags=%b expected 2 0 0 0001 0000",
               db_estado, rodada, endereco, leds, {pronto, ganhou, perdeu, db_timeout});
    end
  endtask

  task automatic test_timeout(input logic fast);
    int tm, tt;
    tm = fast ? 2 : 4;
    tt = fast ? 10 : 20;
    modo = fast;
    start_game();
    playback(0, tm);
    for (int k = 1; k < tt; k++) tick();
    n_checks++;
    if (db_estado !== 4'h4 || perdeu !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_early fast=%0d: estado=%h perdeu=%b expected 4 0", fast, db_estado, perdeu);
    end
    tick();
    n_checks++;
    if (db_estado !== 4'hE || {pronto, ganhou, perdeu, db_timeout} !== 4'b1011) begin
      n_errors++;
      $display("FAIL timeout fast=%0d: estado=%h pgpt=%b expected E 1011",
               fast, db_estado, {pronto, ganhou, perdeu, db_timeout});
    end
    modo = 1'b0;
  endtask

  task automatic test_multi_hot();
    start_game();
    playback(0, 4);
    jogar(4'b0011, 4'hE);
    n_checks++;
    if (perdeu !== 1'b1 || db_timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL multi_hot: perdeu=%b timeout=%b expected 1 0", perdeu, db_timeout);
    end
  endtask

  task automatic test_held_button();
    start_game();
    chaves = 4'b0001;
    playback(0, 4);
    for (int k = 1; k < 20; k++) tick();
    n_checks++;
    if (db_estado !== 4'h4) begin
      n_errors++; $display("FAIL held_no_jogada: estado=%h expected 4", db_estado);
    end
    tick();
    n_checks++;
    if (db_estado !== 4'hE || db_timeout !== 1'b1) begin
      n_errors++;
      $display("FAIL held_timeout: estado=%h timeout=%b expected E 1", db_estado, db_timeout);
    end
    chaves = '0;
  endtask

  task automatic test_reset_mid_show();
    start_game();
    playback(0, 4);
    jogar(4'b0001, 4'h8);
    tick();
    n_checks++;
    if (db_estado !== 4'h2 || rodada !== 2'd1) begin
      n_errors++;
      $display("FAIL mid_show_setup: estado=%h rod=%0d expected 2 1", db_estado, rodada);
    end
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (db_estado !== 4'h0 || leds !== 4'b0 || rodada !== 2'd0 || endereco !== 2'd0 ||
        {pronto, ganhou, perdeu, db_timeout} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_mid_show: estado=%h leds=%b rod=%0d end=%0d flags=%b expected all 0",
               db_estado, leds, rodada, endereco, {pronto, ganhou, perdeu, db_timeout});
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_win();
    test_wrong_play();
    test_restart();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_multi_hot();
    test_held_button();
    test_reset_mid_show();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
